dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder that sits on the far side of the memory stage's data-memory port. It accepts one read or write request at a time, inserts a configurable number of wait states, commits byte-enabled writes to an internal word array and returns a whole aligned word with a one-cycle `dmem_ready` pulse. Lane extraction and sign extension stay in the memory stage; this block is pure storage plus handshake.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words stored.
- `BASE_ADDR`, 32'h1000_0000: byte address of word 0.
- `LATENCY`, 1: wait cycles between acceptance and response, legal range 0..15.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dmem_addr`  in  32  byte address; bits [1:0] are ignored for array indexing.
- `dmem_data_out`  in  32  write data, already placed in its byte lanes.
- `dmem_read`  in  1  read request.
- `dmem_write`  in  1  write request.
- `dmem_byte_enable`  in  4  write lane mask; bit i covers data[8i+7:8i].
- `dmem_data_in`  out  32  read data (whole aligned word), valid while `dmem_ready`=1.
- `dmem_ready`  out  1  one-cycle response pulse.
- `dmem_error`  out  1  qualifies `dmem_ready`: access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A request (`dmem_read`|`dmem_write`) sampled at edge N latches addr, data, byte_enable and op.
  - Next state is RESP if `LATENCY`=0, else WAIT with counter=`LATENCY`-1.
- WAIT: the counter decrements each edge; at 0 the FSM moves to RESP.
- Entry to RESP (registered at the entering edge):
  - A write updates the enabled byte lanes only.
  - A read captures `mem[idx]` into `dmem_data_in`.
  - `dmem_ready`=1, and `dmem_error` is set on rejection.
- RESP always returns to IDLE on the next edge; `dmem_ready` and `dmem_error` clear then.
- `dmem_data_in` holds its last value until the next read response.
- Index: idx=(`dmem_addr`-`BASE_ADDR`)>>2.
- Out of range (`dmem_addr` < `BASE_ADDR`, or idx >= `DEPTH_WORDS`): error response, no write, `dmem_data_in`=0.
- `dmem_read` and `dmem_write` both high at sampling: error response, no write, `dmem_data_in`=0.
- Write with `dmem_byte_enable`=4'b0000: normal response, array unchanged.
- Reads ignore `dmem_byte_enable`.
- A read following a write to the same word returns the updated data.
- Request inputs are ignored outside IDLE. The initiator holds them stable until it sees `dmem_ready`.

## Timing
- The response is visible in the cycle after edge N+`LATENCY` (N = sampling edge).
- Back-to-back throughput: one access per `LATENCY`+2 cycles. The IDLE cycle following RESP samples the next request.
- Reset values: state IDLE, counter 0, `dmem_ready`=0, `dmem_error`=0, `dmem_data_in`=0.
- Array contents are not reset.
- Reset asserted mid-access:
  - Immediate return to IDLE; no response is issued.
  - A write not yet at RESP entry is discarded.
  - After deassertion, the first edge with a request held starts a fresh access.

## Configuration
- `DMEM_BE_CHECK_EN` defined:
  - Writes are legal only with masks 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Any other nonzero mask gets an error response and the array is unchanged.
  - 0000 remains legal.
- `DMEM_BE_CHECK_EN` undefined: every mask is accepted and applied lane by lane.

## Test plan
- `LATENCY`=0 tests:
  - SW 32'h12345678 to 32'h1000_0000, mask 1111 → `dmem_ready` in the cycle after sampling edge, `dmem_error`=0.
  - LW from 32'h1000_0000 → `dmem_data_in`=32'h12345678.
- Byte and half merge:
  - Word 32'hCAFEBABE at 32'h1000_0004.
  - SB data 32'h0000_FF00, mask 0010 → read returns 32'hCAFEFFBE.
  - SH data 32'h8000_0000, mask 1100 → read returns 32'h8000FFBE.
- `LATENCY`=3: a read sampled at edge N → `dmem_ready` low through edge N+2, high for exactly one cycle after edge N+3.
- Error cases:
  - Address 32'h0FFF_FFFC → error response, `dmem_data_in`=0.
  - Address `BASE_ADDR`+4*`DEPTH_WORDS` → same.
  - Read and write both high → error, array unchanged.
- Reset mid-access with `LATENCY`=3: write 32'hDEADBEEF, reset low one cycle after acceptance → no `dmem_ready`, and a later read returns the old contents.
- With `DMEM_BE_CHECK_EN`: write with mask 0101 → error response, word unchanged. Without the macro, the same write updates lanes 0 and 2.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word array with byte-enabled writes, LATENCY wait states
// and a one-cycle ready/error response. Optional write-mask legality check: DMEM_BE_CHECK_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_data_out,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_data_in,
    output logic        dmem_ready,
    output logic        dmem_error
);

    localparam int unsigned IDXW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
    localparam bit          LAT0   = (LATENCY == 0);
    localparam logic [3:0]  LAT_M1 = LAT0 ? 4'd0 : 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        rd_q, wr_q;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        req;
    logic [31:0] a_addr, a_wdata, a_off;
    logic [3:0]  a_be;
    logic        a_rd, a_wr;
    logic        in_range, be_legal, acc_err, go_resp;
    logic [IDXW-1:0] idx;

    assign req = dmem_read | dmem_write;

    // With zero latency the access resolves at the sampling edge, so the
    // live request is used in IDLE; otherwise the latched copy is used.
    always_comb begin
        a_addr  = addr_q;
        a_wdata = wdata_q;
        a_be    = be_q;
        a_rd    = rd_q;
        a_wr    = wr_q;
        if (state_q == S_IDLE) begin
            a_addr  = dmem_addr;
            a_wdata = dmem_data_out;
            a_be    = dmem_byte_enable;
            a_rd    = dmem_read;
            a_wr    = dmem_write;
        end
    end

    assign a_off    = a_addr - BASE_ADDR;
    assign in_range = (a_addr >= BASE_ADDR) && ({1'b0, a_off} < SPAN);
    assign idx      = a_off[IDXW+1:2];

`ifdef DMEM_BE_CHECK_EN
    always_comb begin
        be_legal = 1'b0;
        case (a_be)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
    end
`else
    assign be_legal = 1'b1;
`endif

    assign acc_err = !in_range || (a_rd && a_wr) || (a_wr && !be_legal);
    assign go_resp = (state_q == S_IDLE && req && LAT0) ||
                     (state_q == S_WAIT && cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (LAT0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (go_resp) begin
            ready_d = 1'b1;
            err_d   = acc_err;
            if (acc_err)   rdata_d = 32'd0;
            else if (a_rd) rdata_d = mem[idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (state_q == S_IDLE && req) begin
                addr_q  <= dmem_addr;
                wdata_q <= dmem_data_out;
                be_q    <= dmem_byte_enable;
                rd_q    <= dmem_read;
                wr_q    <= dmem_write;
            end
        end
    end

    // Array is not reset; the reset term only blocks a commit while reset is held.
    always_ff @(posedge clk) begin
        if (reset && go_resp && a_wr && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (a_be[b]) mem[idx][8*b +: 8] <= a_wdata[8*b +: 8];
            end
        end
    end

    assign dmem_data_in = rdata_q;
    assign dmem_ready   = ready_q;
    assign dmem_error   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=0 and a LATENCY=3 instance checked against
// a word-array reference model with directed and randomized accesses.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 1024;

    logic clk;
    logic rst_n;
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic        rd   [2];
    logic        wr   [2];
    logic [3:0]  be   [2];
    logic [31:0] rdata0, rdata3;
    logic        rdy0, rdy3, err0, err3;

    int pas = 0;
    int tot = 0;

    logic [31:0] mdl  [2][DEPTH];
    logic [31:0] last [2];
    int          lat_of [2] = '{0, 3};

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) u_l0 (
        .clk(clk), .reset(rst_n), .dmem_addr(addr[0]), .dmem_data_out(wdat[0]),
        .dmem_read(rd[0]), .dmem_write(wr[0]), .dmem_byte_enable(be[0]),
        .dmem_data_in(rdata0), .dmem_ready(rdy0), .dmem_error(err0));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(rst_n), .dmem_addr(addr[1]), .dmem_data_out(wdat[1]),
        .dmem_read(rd[1]), .dmem_write(wr[1]), .dmem_byte_enable(be[1]),
        .dmem_data_in(rdata3), .dmem_ready(rdy3), .dmem_error(err3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: byte-addressed window over a word array, decided from the address rules.
    function automatic void model(input int i, input logic [31:0] a, d, input logic r, w,
                                  input logic [3:0] m, output logic e, output logic [31:0] q);
        longint off = longint'(a) - longint'(BASE);
        bit bad = (off < 0) || (off / 4 >= DEPTH) || (r && w);
`ifdef DMEM_BE_CHECK_EN
        if (w && !(m inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF})) bad = 1;
`endif
        e = bad;
        if (bad) last[i] = 32'd0;
        else if (w) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) mdl[i][int'(off / 4)][8*b +: 8] = d[8*b +: 8];
        end else last[i] = mdl[i][int'(off / 4)];
        q = last[i];
    endfunction

    // Drives one access (caller is #1 past an edge, DUT idle); reports what it saw.
    task automatic do_access(input int i, input logic [31:0] a, d, input logic r, w,
                             input logic [3:0] m, output logic [31:0] gd, output logic ge,
                             output int glat, output logic pulse1);
        addr[i] = a; wdat[i] = d; rd[i] = r; wr[i] = w; be[i] = m;
        @(posedge clk);
        glat = -1; gd = 32'd0; ge = 1'b0; pulse1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if ((i == 0) ? rdy0 : rdy3) begin
                glat = k;
                gd = (i == 0) ? rdata0 : rdata3;
                ge = (i == 0) ? err0 : err3;
                break;
            end
            @(posedge clk);
        end
        rd[i] = 1'b0; wr[i] = 1'b0;
        @(posedge clk); #1;
        pulse1 = (glat >= 0) && !((i == 0) ? rdy0 : rdy3);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            tot++; if (((i == 0) ? rdy0 : rdy3) !== 1'b0) $display("FAIL reset_ready inst%0d got %b exp 0", i, (i == 0) ? rdy0 : rdy3); else pas++;
            tot++; if (((i == 0) ? err0 : err3) !== 1'b0) $display("FAIL reset_error inst%0d got %b exp 0", i, (i == 0) ? err0 : err3); else pas++;
            tot++; if (((i == 0) ? rdata0 : rdata3) !== 32'd0) $display("FAIL reset_data inst%0d got %h exp 0", i, (i == 0) ? rdata0 : rdata3); else pas++;
        end
    endtask

    task automatic test_sw_lw;
        logic [31:0] gd, ed; logic ge, ee, p; int gl;
        model(0, BASE, 32'h12345678, 0, 1, 4'hF, ee, ed);
        do_access(0, BASE, 32'h12345678, 0, 1, 4'hF, gd, ge, gl, p);
        tot++; if (gl !== 0) $display("FAIL sw_latency got %0d exp 0", gl); else pas++;
        tot++; if (ge !== 1'b0) $display("FAIL sw_error got %b exp 0", ge); else pas++;
        tot++; if (p !== 1'b1) $display("FAIL sw_pulse got %b exp 1", p); else pas++;
        model(0, BASE, 0, 1, 0, 4'h0, ee, ed);
        do_access(0, BASE, 0, 1, 0, 4'h0, gd, ge, gl, p);
        tot++; if (gd !== 32'h12345678) $display("FAIL lw_data got %h exp 12345678", gd); else pas++;
    endtask

    task automatic test_merge;
        logic [31:0] gd, ed; logic ge, ee, p; int gl;
        model(0, BASE + 4, 32'hCAFEBABE, 0, 1, 4'hF, ee, ed);
        do_access(0, BASE + 4, 32'hCAFEBABE, 0, 1, 4'hF, gd, ge, gl, p);
        model(0, BASE + 4, 32'h0000FF00, 0, 1, 4'h2, ee, ed);
        do_access(0, BASE + 5, 32'h0000FF00, 0, 1, 4'h2, gd, ge, gl, p);
        model(0, BASE + 4, 0, 1, 0, 4'h0, ee, ed);
        do_access(0, BASE + 4, 0, 1, 0, 4'h0, gd, ge, gl, p);
        tot++; if (gd !== 32'hCAFEFFBE) $display("FAIL sb_merge got %h exp CAFEFFBE", gd); else pas++;
        model(0, BASE + 4, 32'h80000000, 0, 1, 4'hC, ee, ed);
        do_access(0, BASE + 6, 32'h80000000, 0, 1, 4'hC, gd, ge, gl, p);
        model(0, BASE + 4, 0, 1, 0, 4'h0, ee, ed);
        do_access(0, BASE + 4, 0, 1, 0, 4'h0, gd, ge, gl, p);
        tot++; if (gd !== 32'h8000FFBE) $display("FAIL sh_merge got %h exp 8000FFBE", gd); else pas++;
    endtask

    task automatic test_latency3;
        logic [31:0] gd, ed; logic ge, ee, p; int gl;
        model(1, BASE, 32'h0BADF00D, 0, 1, 4'hF, ee, ed);
        do_access(1, BASE, 32'h0BADF00D, 0, 1, 4'hF, gd, ge, gl, p);
        tot++; if (gl !== 3) $display("FAIL l3_wr_latency got %0d exp 3", gl); else pas++;
        model(1, BASE, 0, 1, 0, 4'h0, ee, ed);
        do_access(1, BASE, 0, 1, 0, 4'h0, gd, ge, gl, p);
        tot++; if (gl !== 3) $display("FAIL l3_rd_latency got %0d exp 3", gl); else pas++;
        tot++; if (p !== 1'b1) $display("FAIL l3_pulse got %b exp 1", p); else pas++;
        tot++; if (gd !== 32'h0BADF00D) $display("FAIL l3_rd_data got %h exp 0BADF00D", gd); else pas++;
    endtask

    task automatic test_errors;
        logic [31:0] gd, ed; logic ge, ee, p; int gl;
        do_access(0, 32'h0FFFFFFC, 0, 1, 0, 4'h0, gd, ge, gl, p);
        model(0, 32'h0FFFFFFC, 0, 1, 0, 4'h0, ee, ed);
        tot++; if (ge !== 1'b1 || gd !== 32'd0) $display("FAIL err_below got err=%b data=%h exp err=1 data=0", ge, gd); else pas++;
        model(0, BASE, 0, 1, 0, 4'h0, ee, ed);
        do_access(0, BASE, 0, 1, 0, 4'h0, gd, ge, gl, p);
        do_access(0, BASE + 4 * DEPTH, 0, 1, 0, 4'h0, gd, ge, gl, p);
        model(0, BASE + 4 * DEPTH, 0, 1, 0, 4'h0, ee, ed);
        tot++; if (ge !== 1'b1 || gd !== 32'd0) $display("FAIL err_above got err=%b data=%h exp err=1 data=0", ge, gd); else pas++;
        do_access(0, BASE, 32'hFFFFFFFF, 1, 1, 4'hF, gd, ge, gl, p);
        model(0, BASE, 32'hFFFFFFFF, 1, 1, 4'hF, ee, ed);
        tot++; if (ge !== 1'b1 || gd !== 32'd0) $display("FAIL err_both got err=%b data=%h exp err=1 data=0", ge, gd); else pas++;
        model(0, BASE, 0, 1, 0, 4'h0, ee, ed);
        do_access(0, BASE, 0, 1, 0, 4'h0, gd, ge, gl, p);
        tot++; if (gd !== 32'h12345678) $display("FAIL err_both_nowrite got %h exp 12345678", gd); else pas++;
    endtask

    task automatic test_be_mask;
        logic [31:0] gd, ed, exp_w; logic ge, ee, p, exp_e; int gl;
`ifdef DMEM_BE_CHECK_EN
        exp_w = 32'h0; exp_e = 1'b1;
`else
        exp_w = 32'h00B200D4; exp_e = 1'b0;
`endif
        model(0, BASE + 8, 0, 0, 1, 4'hF, ee, ed);
        do_access(0, BASE + 8, 0, 0, 1, 4'hF, gd, ge, gl, p);
        model(0, BASE + 8, 32'hA1B2C3D4, 0, 1, 4'h5, ee, ed);
        do_access(0, BASE + 8, 32'hA1B2C3D4, 0, 1, 4'h5, gd, ge, gl, p);
        tot++; if (ge !== exp_e) $display("FAIL be0101_error got %b exp %b", ge, exp_e); else pas++;
        model(0, BASE + 8, 32'hFFFFFFFF, 0, 1, 4'h0, ee, ed);
        do_access(0, BASE + 8, 32'hFFFFFFFF, 0, 1, 4'h0, gd, ge, gl, p);
        tot++; if (ge !== 1'b0) $display("FAIL be0000_error got %b exp 0", ge); else pas++;
        model(0, BASE + 8, 0, 1, 0, 4'h0, ee, ed);
        do_access(0, BASE + 8, 0, 1, 0, 4'h0, gd, ge, gl, p);
        tot++; if (gd !== exp_w) $display("FAIL be_word got %h exp %h", gd, exp_w); else pas++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] gd, ed; logic ge, ee, p; int gl; int seen;
        model(1, BASE + 16, 32'h11112222, 0, 1, 4'hF, ee, ed);
        do_access(1, BASE + 16, 32'h11112222, 0, 1, 4'hF, gd, ge, gl, p);
        addr[1] = BASE + 16; wdat[1] = 32'hDEADBEEF; wr[1] = 1'b1; be[1] = 4'hF;
        @(posedge clk);
        seen = 0;
        @(posedge clk); #1;
        rst_n = 1'b0; wr[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (rdy3) seen++;
            if (k == 2) rst_n = 1'b1;
        end
        last[0] = 32'd0; last[1] = 32'd0;
        tot++; if (seen !== 0) $display("FAIL rst_mid_noresp got %0d pulses exp 0", seen); else pas++;
        tot++; if (rdata3 !== 32'd0) $display("FAIL rst_mid_data got %h exp 0", rdata3); else pas++;
        model(1, BASE + 16, 0, 1, 0, 4'h0, ee, ed);
        do_access(1, BASE + 16, 0, 1, 0, 4'h0, gd, ge, gl, p);
        tot++; if (gd !== 32'h11112222) $display("FAIL rst_mid_old got %h exp 11112222", gd); else pas++;
    endtask

    task automatic test_random;
        logic [31:0] gd, ed, a, d; logic ge, ee, p, r, w; logic [3:0] m; int gl, sel;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k <= 16; k++) begin
                a = (k == 16) ? BASE + 4 * (DEPTH - 1) : BASE + 32'(4 * k);
                d = $urandom;
                model(i, a, d, 0, 1, 4'hF, ee, ed);
                do_access(i, a, d, 0, 1, 4'hF, gd, ge, gl, p);
            end
            for (int n = 0; n < 80; n++) begin
                sel = $urandom_range(0, 19);
                if (sel == 0)      a = BASE - 32'(4 * $urandom_range(1, 8));
                else if (sel == 1) a = BASE + 4 * DEPTH + 32'($urandom_range(0, 7));
                else if (sel == 2) a = BASE + 4 * (DEPTH - 1) + 32'($urandom_range(0, 3));
                else               a = BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
                sel = $urandom_range(0, 9);
                r = (sel < 5) || (sel == 9);
                w = (sel >= 5);
                d = $urandom; m = 4'($urandom);
                model(i, a, d, r, w, m, ee, ed);
                do_access(i, a, d, r, w, m, gd, ge, gl, p);
                tot++; if (gl !== lat_of[i]) $display("FAIL rnd_latency inst%0d n%0d got %0d exp %0d", i, n, gl, lat_of[i]); else pas++;
                tot++; if (p !== 1'b1) $display("FAIL rnd_pulse inst%0d n%0d got %b exp 1", i, n, p); else pas++;
                tot++; if (ge !== ee) $display("FAIL rnd_error inst%0d n%0d a=%h got %b exp %b", i, n, a, ge, ee); else pas++;
                tot++; if (gd !== ed) $display("FAIL rnd_data inst%0d n%0d a=%h got %h exp %h", i, n, a, gd, ed); else pas++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdat[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; be[i] = '0; last[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_sw_lw;
        test_merge;
        test_latency3;
        test_errors;
        test_be_mask;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", pas, tot);
        $finish;
    end

endmodule
